keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad on a Pmod header. This is the input-side counterpart of the multiplexed seven-segment display driver.
- Drives one active-low column per scan slot and samples the active-low rows.
- Debounces whole scan frames and emits a one-cycle key event with a hex code to the terminal input path.
- Shares the slow scan strobe (cke) with the display driver.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key map for the matrix keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED
  } state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_t;

  // Indexed by col*4+row; element 0 is the rightmost nibble.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with whole-frame debounce
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cke,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE);

  logic [3:0]  w_row_sync;
  logic [3:0]  w_rs;
  logic [1:0]  r_select;
  logic [1:0]  w_select_next;
  logic [3:0]  r_col;
  logic [15:0] r_frame;
  logic        r_frame_done;

  logic [4:0]  w_ones;
  logic [3:0]  w_hit_idx;
  frame_t      w_frame_res;
  logic [3:0]  w_frame_code;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_count;
  logic [3:0]  w_count_next;
  logic [3:0]  w_count_inc;
  logic [3:0]  r_cand;
  logic [3:0]  w_cand_next;
  logic [3:0]  r_key_code;
  logic [3:0]  w_key_code_next;
  logic        r_key_valid;
  logic        w_key_valid_next;
  logic        r_key_down;
  logic        w_key_down_next;

  // Pull-ups make an idle row read high, so the synchronizer resets to "released".
  sync_2ff #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (row),
    .o_q   (w_row_sync)
  );

  assign w_rs          = ~w_row_sync;
  assign w_select_next = r_select + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_select     <= 2'd0;
      r_col        <= 4'b1110;
      r_frame      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_frame_done) begin
        r_frame <= '0;
      end
      if (cke) begin
        r_frame[{r_select, 2'b00} +: 4] <= w_rs;
        r_select     <= w_select_next;
        r_col        <= ~(4'b0001 << w_select_next);
        r_frame_done <= (r_select == 2'd3);
      end
    end
  end

  always_comb begin
    w_ones    = '0;
    w_hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_frame[i]) begin
        w_ones    = w_ones + 5'd1;
        w_hit_idx = 4'(i);
      end
    end
    if (w_ones == 5'd0) begin
      w_frame_res = FR_NONE;
    end else if (w_ones == 5'd1) begin
      w_frame_res = FR_SINGLE;
    end else begin
      w_frame_res = FR_MULTI;
    end
  end

  assign w_frame_code = KEYMAP[w_hit_idx];
  assign w_count_inc  = r_count + 4'd1;

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_cand_next      = r_cand;
    w_key_code_next  = r_key_code;
    w_key_valid_next = 1'b0;
    w_key_down_next  = r_key_down;
    if (r_frame_done) begin
      case (r_state)
        ST_IDLE: begin
          if (w_frame_res == FR_SINGLE) begin
            w_cand_next = w_frame_code;
            if (DB_LIMIT == 4'd1) begin
              w_state_next     = ST_PRESSED;
              w_count_next     = 4'd0;
              w_key_code_next  = w_frame_code;
              w_key_valid_next = 1'b1;
              w_key_down_next  = 1'b1;
            end else begin
              w_state_next = ST_DEBOUNCE;
              w_count_next = 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_frame_res == FR_SINGLE && w_frame_code == r_cand) begin
            if (w_count_inc == DB_LIMIT) begin
              w_state_next     = ST_PRESSED;
              w_count_next     = 4'd0;
              w_key_code_next  = r_cand;
              w_key_valid_next = 1'b1;
              w_key_down_next  = 1'b1;
            end else begin
              w_count_next = w_count_inc;
            end
          end else if (w_frame_res == FR_SINGLE) begin
            w_cand_next  = w_frame_code;
            w_count_next = 4'd1;
          end else begin
            w_state_next = ST_IDLE;
            w_count_next = 4'd0;
          end
        end
        ST_PRESSED: begin
          // Any activity while held restarts the release count; no rollover events.
          if (w_frame_res == FR_NONE) begin
            if (w_count_inc == DB_LIMIT) begin
              w_state_next    = ST_IDLE;
              w_count_next    = 4'd0;
              w_key_down_next = 1'b0;
            end else begin
              w_count_next = w_count_inc;
            end
          end else begin
            w_count_next = 4'd0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_count_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= 4'd0;
      r_cand      <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_cand      <= w_cand_next;
      r_key_code  <= w_key_code_next;
      r_key_valid <= w_key_valid_next;
      r_key_down  <= w_key_down_next;
    end
  end

  assign col       = r_col;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int D = 4;
  localparam logic [3:0] HEXMAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_pass   = 0;

  int         pulse_cnt  = 0;
  logic [3:0] pulse_code = '0;
  logic       pulse_rise = 1'b0;
  logic       prev_down  = 1'b0;

  int         hist[$];
  bit         m_down = 1'b0;
  logic [3:0] m_code = '0;

  always #5 clk = ~clk;

  keypad_scanner #(.DEBOUNCE(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .cke       (cke),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down)
  );

  // Passive matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_down <= 1'b0;
    end else begin
      if (key_valid) begin
        pulse_cnt  <= pulse_cnt + 1;
        pulse_code <= key_code;
        pulse_rise <= key_down && !prev_down;
      end
      prev_down <= key_down;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] kb(input logic [3:0] code);
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++)
      if (HEXMAP[i] == code) v[i] = 1'b1;
    return v;
  endfunction

  // Press accepted when the last D frames all show the same lone key while released;
  // release accepted when the last D frames are all empty while held.
  task automatic model_frame(input logic [15:0] k, output bit ev);
    int cls;
    bit same;
    ev = 1'b0;
    if ($countones(k) == 0) cls = -1;
    else if ($countones(k) > 1) cls = -2;
    else begin
      cls = 0;
      for (int i = 0; i < 16; i++) if (k[i]) cls = int'(HEXMAP[i]);
    end
    hist.push_back(cls);
    if (hist.size() > D) void'(hist.pop_front());
    if (hist.size() == D) begin
      same = 1'b1;
      for (int i = 1; i < D; i++) if (hist[i] != hist[0]) same = 1'b0;
      if (!m_down && same && hist[0] >= 0) begin
        ev     = 1'b1;
        m_down = 1'b1;
        m_code = 4'(hist[0]);
      end else if (m_down && same && hist[0] == -1) begin
        m_down = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] k);
    int p0;
    bit ev;
    logic [3:0] exp_col;
    keys = k;
    p0   = pulse_cnt;
    for (int s = 0; s < 4; s++) begin
      repeat (s == 0 ? 4 : 7) @(posedge clk);
      #1 cke = 1'b1;
      @(posedge clk);
      #1 cke = 1'b0;
      exp_col = ~(4'b0001 << ((s + 1) % 4));
      check("col", 32'(col), 32'(exp_col));
    end
    repeat (3) @(posedge clk);
    #1;
    model_frame(k, ev);
    check("pulses", 32'(pulse_cnt - p0), 32'(ev));
    if (ev) begin
      check("code_at_pulse", 32'(pulse_code), 32'(m_code));
      check("down_rise_with_valid", 32'(pulse_rise), 32'd1);
    end
    check("key_down", 32'(key_down), 32'(m_down));
    check("key_code", 32'(key_code), 32'(m_code));
  endtask

  task automatic check_reset_values();
    check("rst_col", 32'(col), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_down", 32'(key_down), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
  endtask

  initial begin
    logic [15:0] k;
    int kind;
    int hold;

    repeat (3) @(posedge clk);
    #1 check_reset_values();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_frame(kb(4'h5));
    for (int i = 0; i < 6; i++) run_frame('0);

    for (int i = 0; i < 12; i++) run_frame(((i / 2) % 2 == 0) ? kb(4'hA) : 16'h0);
    for (int i = 0; i < 5; i++) run_frame(kb(4'hA));
    for (int i = 0; i < 5; i++) run_frame('0);

    for (int i = 0; i < 8; i++) run_frame(kb(4'h1) | kb(4'h2));
    for (int i = 0; i < 5; i++) run_frame(kb(4'h1));
    for (int i = 0; i < 5; i++) run_frame('0);

    for (int i = 0; i < 5; i++) run_frame(kb(4'hD));
    for (int i = 0; i < 3; i++) run_frame(kb(4'hD) | kb(4'h0));
    for (int i = 0; i < 5; i++) run_frame('0);

    for (int i = 0; i < 3; i++) run_frame(kb(4'h1) | kb(4'h4) | kb(4'h2));
    run_frame('0);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 6);
      if (kind == 0) k = '0;
      else if (kind == 3) k = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
      else k = 16'd1 << $urandom_range(0, 15);
      for (int h = 0; h < hold; h++) run_frame(k);
    end
    for (int i = 0; i < 5; i++) run_frame('0);

    for (int i = 0; i < 5; i++) run_frame(kb(4'h7));
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    #2 check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();
    m_down = 1'b0;
    m_code = '0;
    for (int i = 0; i < 6; i++) run_frame(kb(4'h7));
    for (int i = 0; i < 5; i++) run_frame('0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
